// File: rtl/alu_pkg.sv
// Shared definitions for the lab ALU: operand-loader FSM state codes and
// the bit positions of the {C,N,V,Z} flag register.
package alu_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } state_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single-cycle press pulse: two-flop synchronizer followed
// by a stability counter that fires once per press and re-arms on release.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          pulse_q, pulse_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        pulse_d = 1'b0;
        if (!sync_q[1]) begin
            cnt_d = '0;
            acc_d = 1'b0;
        end else if (!acc_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                cnt_d   = CW'(DB_CYCLES);
                acc_d   = 1'b1;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand/opcode loader for the lab ALU: steps A -> B -> opcode on debounced
// ENTER presses, then captures the ALU result and flags every cycle in EXEC.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int          M         = 4,
    parameter int          OPW       = 4,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   sw,
    input  logic           btn_enter,
    input  logic           btn_clear,
    input  logic [M-1:0]   alu_r,
    input  logic           alu_c,
    input  logic           alu_n,
    input  logic           alu_v,
    input  logic           alu_z,
    output logic [M-1:0]   a,
    output logic [M-1:0]   b,
    output logic [OPW-1:0] op,
    output logic           valid,
    output logic [M-1:0]   res,
    output logic [3:0]     flags,
    output logic [1:0]     state
);

    logic enter_pulse, clear_pulse;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (enter_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .pulse (clear_pulse)
    );

    state_e         state_q;
    logic [M-1:0]   a_q, b_q, res_q;
    logic [OPW-1:0] op_q;
    logic [3:0]     flags_q;
    logic           valid_q;

    // Clear shares the reset path, so a simultaneous enter pulse is dropped.
    always_ff @(posedge clk) begin
        if (rst || clear_pulse) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state_q == EXEC) begin
                res_q           <= alu_r;
                flags_q[FLAG_C] <= alu_c;
                flags_q[FLAG_N] <= alu_n;
                flags_q[FLAG_V] <= alu_v;
                flags_q[FLAG_Z] <= alu_z;
            end
            if (enter_pulse) begin
                case (state_q)
                    LOAD_A: begin
                        a_q     <= sw;
                        state_q <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_q     <= sw;
                        state_q <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        op_q    <= sw[OPW-1:0];
                        state_q <= EXEC;
                        valid_q <= 1'b1;
                    end
                    EXEC: begin
                        state_q <= LOAD_A;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign valid = valid_q;
    assign res   = res_q;
    assign flags = flags_q;
    assign state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small behavioural ALU on the
// result/flag inputs; expected values are hand-computed constants.
module tb_alu_operand_loader;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SHR = 4'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] alu_r;
    logic       alu_c, alu_n, alu_v, alu_z;
    logic [3:0] a, b, op, res, flags;
    logic       valid;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(.M(4), .OPW(4), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .alu_r     (alu_r),
        .alu_c     (alu_c),
        .alu_n     (alu_n),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid     (valid),
        .res       (res),
        .flags     (flags),
        .state     (state)
    );

    // Combinational ALU stand-in: add, logical shift right, otherwise AND.
    always_comb begin
        logic [4:0] sum;
        sum   = {1'b0, a} + {1'b0, b};
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (op == OP_ADD) begin
            alu_r = sum[3:0];
            alu_c = sum[4];
            alu_v = (a[3] == b[3]) && (sum[3] != a[3]);
        end else if (op == OP_SHR) begin
            alu_r = a >> b;
        end else begin
            alu_r = a & b;
        end
        alu_n = alu_r[3];
        alu_z = (alu_r == 4'd0);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic v,
                             input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eop,
                             input logic [3:0] eres, input logic [3:0] efl);
        check({tag, "_state"}, {6'd0, state}, {6'd0, st});
        check({tag, "_valid"}, {7'd0, valid}, {7'd0, v});
        check({tag, "_a"},     {4'd0, a},     {4'd0, ea});
        check({tag, "_b"},     {4'd0, b},     {4'd0, eb});
        check({tag, "_op"},    {4'd0, op},    {4'd0, eop});
        check({tag, "_res"},   {4'd0, res},   {4'd0, eres});
        check({tag, "_flags"}, {4'd0, flags}, {4'd0, efl});
    endtask

    // Raise enter and poll (bounded) until the FSM reaches tgt; button stays high.
    task automatic raise_and_wait(input logic [1:0] tgt, input string tag);
        logic found;
        found = 1'b0;
        btn_enter = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state === tgt) found = 1'b1;
        end
        check({tag, "_reached"}, {7'd0, found}, 8'd1);
    endtask

    task automatic release_enter(input int hold);
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Enter held high across exactly n rising edges, then released.
    task automatic pulse_enter(input int n);
        btn_enter = 1'b1;
        repeat (n) @(negedge clk);
        btn_enter = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_all("reset", 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Three synced cycles is one short of DB_CYCLES: no pulse.
        sw = 4'b1000;
        pulse_enter(3);
        check("glitch3_state", {6'd0, state}, 8'd0);
        check("glitch3_a", {4'd0, a}, 8'd0);

        // Held for 50 cycles: one pulse only.
        raise_and_wait(2'd1, "loada");
        release_enter(50);
        check("hold50_state", {6'd0, state}, 8'd1);
        check("hold50_a", {4'd0, a}, 8'd8);

        // Exactly DB_CYCLES synced cycles is enough.
        sw = 4'b0001;
        pulse_enter(4);
        check("press4_state", {6'd0, state}, 8'd2);
        check("press4_b", {4'd0, b}, 8'd1);

        sw = OP_SHR;
        raise_and_wait(2'd3, "loadop");
        check_all("exec0", 2'd3, 1'b1, 4'd8, 4'd1, OP_SHR, 4'd0, 4'd0);
        @(negedge clk);
        check("exec1_res", {4'd0, res}, 8'd4);
        check("exec1_flags", {4'd0, flags}, 8'd0);
        release_enter(2);
        check_all("exec_hold", 2'd3, 1'b1, 4'd8, 4'd1, OP_SHR, 4'd4, 4'd0);

        // Clear and enter pressed together: clear wins.
        btn_clear = 1'b1;
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        repeat (6) @(negedge clk);
        check_all("clear_enter", 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Reset mid-press in LOAD_OP.
        sw = 4'd5;
        pulse_enter(8);
        sw = 4'd2;
        pulse_enter(8);
        check_all("pre_rst", 2'd2, 1'b0, 4'd5, 4'd2, 4'd0, 4'd0, 4'd0);
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        btn_enter = 1'b0;
        @(negedge clk);
        check_all("rst_mid", 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_all("rst_after", 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Full loop with ADD: 12 + 6 = 18 -> r=2, C=1, N=0, V=0, Z=0.
        sw = 4'd12;
        pulse_enter(8);
        sw = 4'd6;
        pulse_enter(8);
        sw = OP_ADD;
        pulse_enter(8);
        check_all("add_exec", 2'd3, 1'b1, 4'd12, 4'd6, OP_ADD, 4'd2, 4'b1000);
        sw = 4'd15;
        pulse_enter(8);
        check_all("exec_exit", 2'd0, 1'b0, 4'd12, 4'd6, OP_ADD, 4'd2, 4'b1000);
        sw = 4'd9;
        pulse_enter(8);
        check_all("new_a", 2'd1, 1'b0, 4'd9, 4'd6, OP_ADD, 4'd2, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
